// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, instruction fields.
// Optional flag outputs are enabled in the top with ALU_SEQ_FLAGS_EN.
package alu_seq_pkg;

  localparam int NUM_OPS = 9;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd9;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_W   = 9;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RETIRE} state_t;

  // One-hot strobe vector, bit i drives the logic_unit operation with opcode i.
  function automatic logic [NUM_OPS-1:0] op_strobes(input logic [3:0] op);
    logic [NUM_OPS-1:0] s;
    s = '0;
    case (op)
      OP_PASS: s[0] = 1'b1;
      OP_ADD:  s[1] = 1'b1;
      OP_SUB:  s[2] = 1'b1;
      OP_SHR:  s[3] = 1'b1;
      OP_SHL:  s[4] = 1'b1;
      OP_AND:  s[5] = 1'b1;
      OP_OR:   s[6] = 1'b1;
      OP_XOR:  s[7] = 1'b1;
      OP_NOT:  s[8] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LDI;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: two combinational read ports,
// one synchronous write port, asynchronous clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [REG_CNT-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem <= '0;
    else if (we) mem[wa] <= wd;
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of logic_unit: fetch handshake, operand read, strobe, writeback.
// Define ALU_SEQ_FLAGS_EN to add zero_flag/neg_flag outputs tracking the last writeback.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              passthrough,
  output logic              add,
  output logic              sub,
  output logic              shr,
  output logic              shl,
  output logic              band,
  output logic              bor,
  output logic              bxor,
  output logic              bnegate,
  output logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] bus2,
  input  logic [DATA_W-1:0] bus3,
  output logic              done,
  output logic              illegal
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              neg_flag
`endif
);

  localparam int AW = $clog2(REG_CNT);

  state_t              state_q, state_n;
  logic [15:0]         ir_q;
  logic                ready_q;
  logic [NUM_OPS-1:0]  stb;
  logic [3:0]          op;
  logic [AW-1:0]       rd_a, rs1_a, rs2_a;
  logic [DATA_W-1:0]   rd1, rd2, wd, imm_ext;
  logic                we;
  logic                accept;

  assign op      = ir_q[OPC_LSB +: 4];
  assign rd_a    = ir_q[RD_LSB  +: AW];
  assign rs1_a   = ir_q[RS1_LSB +: AW];
  assign rs2_a   = ir_q[RS2_LSB +: AW];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign accept  = (state_q == IDLE) && instr_valid && ready_q;

  alu_seq_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_a),
    .ra2 (rs2_a),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (we),
    .wa  (rd_a),
    .wd  (wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // ready is registered so it stays low for the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      ir_q    <= '0;
      bus1    <= '0;
      bus2    <= '0;
    end else begin
      ready_q <= (state_n == IDLE);
      if (accept) ir_q <= instr;
      if (state_q == READ) begin
        bus1 <= rd1;
        bus2 <= rd2;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    stb     = '0;
    done    = 1'b0;
    illegal = 1'b0;
    we      = 1'b0;
    wd      = bus3;
    case (state_q)
      IDLE:   if (accept) state_n = READ;
      READ:   state_n = EXEC;
      EXEC: begin
        state_n = RETIRE;
        stb     = op_strobes(op);
        // bus3 is only meaningful here, while a strobe is driving logic_unit.
        if (op <= OP_NOT) we = 1'b1;
        else if (op == OP_LDI) begin
          we = 1'b1;
          wd = imm_ext;
        end
      end
      RETIRE: begin
        state_n = IDLE;
        done    = 1'b1;
        illegal = is_illegal(op);
      end
      default: state_n = IDLE;
    endcase
  end

  assign {bnegate, bxor, bor, band, shl, shr, sub, add, passthrough} = stb;
  assign instr_ready = ready_q;

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (we) begin
      zero_flag <= (wd == '0);
      neg_flag  <= wd[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a transaction-level register model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, passthrough, add, sub, shr, shl, band, bor, bxor, bnegate;
  logic [15:0] bus1, bus2, bus3;
  logic        done, illegal;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .passthrough(passthrough), .add(add), .sub(sub), .shr(shr), .shl(shl),
    .band(band), .bor(bor), .bxor(bxor), .bnegate(bnegate),
    .bus1(bus1), .bus2(bus2), .bus3(bus3), .done(done), .illegal(illegal)
`ifdef ALU_SEQ_FLAGS_EN
    , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
  );

  wire [8:0] stb = {bnegate, bxor, bor, band, shl, shr, sub, add, passthrough};

  // logic_unit stand-in; when no strobe is high the bus carries junk instead of a value.
  function automatic logic [15:0] lu(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      0: return a;
      1: return a + b;
      2: return a - b;
      3: return a >> 1;
      4: return a << 1;
      5: return a & b;
      6: return a | b;
      7: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  logic [15:0] junk = 16'hDEAD;
  always @(posedge clk) junk <= 16'($urandom);

  always_comb begin
    bus3 = junk;
    for (int i = 0; i < 9; i++) if (stb[i]) bus3 = lu(i, bus1, bus2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus a count of cycles into the current instruction.
  logic [15:0] R [8];
  int          ph;
  logic        post_rst;
  logic [15:0] mir, b1, b2, mv;
  logic        zf, nf;
  logic [8:0]  es;

  always_comb mv = (mir[15:12] == 4'd9) ? {7'b0, mir[8:0]} : lu(int'(mir[15:12]), b1, b2);

  always_comb begin
    es = '0;
    if (ph == 2 && mir[15:12] <= 4'd8) es[mir[15:12]] = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; post_rst <= 1'b0; mir <= '0; b1 <= '0; b2 <= '0; zf <= 1'b0; nf <= 1'b0;
      for (int i = 0; i < 8; i++) R[i] <= '0;
    end else begin
      post_rst <= 1'b1;
      case (ph)
        0: if (post_rst && instr_valid) begin mir <= instr; ph <= 1; end
        1: begin b1 <= R[mir[8:6]]; b2 <= R[mir[5:3]]; ph <= 2; end
        2: begin
          if (mir[15:12] <= 4'd9) begin
            R[mir[11:9]] <= mv;
            zf <= (mv == 16'd0);
            nf <= mv[15];
          end
          ph <= 3;
        end
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("ready", instr_ready, (ph == 0) && post_rst);
    chk("strobes", stb, es);
    chk("onehot0", $onehot0(stb), 1);
    chk("done", done, ph == 3);
    chk("illegal", illegal, (ph == 3) && (mir[15:12] >= 4'd10));
    chk("bus1", bus1, b1);
    chk("bus2", bus2, b2);
`ifdef ALU_SEQ_FLAGS_EN
    chk("zero_flag", zero_flag, zf);
    chk("neg_flag", neg_flag, nf);
`endif
  end

  function automatic logic [15:0] ins(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b0};
  endfunction
  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'd9, 3'(rd), 9'(imm)};
  endfunction

  // Called #2 after a rising edge; returns #2 after the handshake edge (instruction in READ).
  task automatic issue(input logic [15:0] w, input bit keep, output int waited);
    logic r;
    instr = w; instr_valid = 1'b1; waited = 0;
    for (int n = 0; n < 16; n++) begin
      r = instr_ready;
      @(posedge clk); #2;
      waited++;
      if (r) begin
        if (!keep) instr_valid = 1'b0;
        return;
      end
    end
    instr_valid = 1'b0;
    compared++; mismatched++;
    $display("FAIL issue_timeout: instr %h not accepted, expected within 16 cycles", w);
  endtask

  task automatic check_reg(input int r, input logic [15:0] val);
    int w;
    issue(ins(0, r, r, 0), 1'b0, w);
    @(posedge clk); #2;
    chk($sformatf("reg_r%0d", r), bus1, val);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int w;
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset values.
    cyc(2);
    chk("rst_ready", instr_ready, 0); chk("rst_bus1", bus1, 0); chk("rst_bus2", bus2, 0);
    chk("rst_done", done, 0); chk("rst_illegal", illegal, 0); chk("rst_strobes", stb, 0);
    rst = 1'b0;
    chk("ready_after_rst0", instr_ready, 0);
    cyc(1);
    chk("ready_after_rst1", instr_ready, 1);

    // Reset while ADD sits in EXEC aborts writeback.
    issue(ldi(2, 7), 0, w);
    issue(ldi(3, 9), 0, w);
    issue(ins(1, 1, 2, 3), 0, w);
    cyc(1);
    chk("abort_add_hi", add, 1);
    #1 rst = 1'b1;
    #1 chk("abort_strobes", stb, 0);
    cyc(1);
    rst = 1'b0;
    chk("abort_ready0", instr_ready, 0);
    cyc(1);
    chk("abort_ready1", instr_ready, 1);
    check_reg(1, 16'd0);

    // ADD timing and operands.
    issue(ldi(2, 3), 0, w);
    issue(ldi(3, 2), 0, w);
    issue(ins(1, 1, 2, 3), 0, w);
    chk("add_c1_strobes", stb, 0);
    cyc(1);
    chk("add_c2_add", add, 1); chk("add_c2_bus1", bus1, 3); chk("add_c2_bus2", bus2, 2);
    chk("add_c2_done", done, 0);
    cyc(1);
    chk("add_c3_done", done, 1); chk("add_c3_strobes", stb, 0);
    check_reg(1, 16'd5);

    issue(ins(2, 4, 2, 3), 0, w);
    issue(ins(0, 5, 4, 0), 0, w);
    check_reg(4, 16'd1);
    check_reg(5, 16'd1);

    issue(ins(2, 6, 3, 2), 0, w);
    cyc(2);
`ifdef ALU_SEQ_FLAGS_EN
    chk("sub_neg_flag", neg_flag, 1); chk("sub_zero_flag", zero_flag, 0);
`endif
    check_reg(6, 16'hFFFF);

    // Unsupported opcode.
    issue(ins(12, 1, 2, 3), 0, w);
    cyc(1);
    chk("ill_c2_strobes", stb, 0);
    cyc(1);
    chk("ill_c3_done", done, 1); chk("ill_c3_illegal", illegal, 1);
    check_reg(1, 16'd5);

    // Back-to-back with instr_valid held high.
    issue(ins(1, 2, 2, 2), 1, w);
    issue(ins(0, 2, 2, 0), 1, w);
    chk("b2b_gap", w, 4);
    cyc(1);
    chk("b2b_add_r2", bus1, 16'd6);
    instr_valid = 1'b0;

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int i = 0; i < 8; i++) issue(ldi(i, int'($urandom_range(0, 511))), 0, w);
    for (int i = 0; i < 80; i++) begin
      cyc(int'($urandom_range(0, 2)));
      issue(16'($urandom), bit'($urandom_range(0, 1)), w);
    end
    instr_valid = 1'b0;
    cyc(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for logic_unit: accepts one 16-bit instruction at a time over a valid/ready handshake.
- Reads two operands from an internal 8x16 register file and drives them onto bus1/bus2.
- Asserts exactly one logic_unit operation strobe, captures bus3, and writes the result back to the destination register.
- Sits between instruction fetch and logic_unit; owns the register file.

Parameters:
- DATA_W, 16, datapath width of bus1/bus2/bus3 and registers.
- REG_CNT, 8, number of registers; address width is log2(REG_CNT) = 3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] reserved.
- passthrough, add, sub, shr, shl, band, bor, bxor, bnegate  out  1 each  one-hot operation strobes to logic_unit.
- bus1  out  DATA_W  operand A (R[rs1]).
- bus2  out  DATA_W  operand B (R[rs2]).
- bus3  in  DATA_W  logic_unit result; high-Z when no strobe is active.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an unsupported opcode retires.

Behaviour:
- Reset values: all strobes 0, bus1 = bus2 = 0, instr_ready 0, done 0, illegal 0, all registers 0, state IDLE. Reset is asynchronous and may assert in any state; it aborts the instruction in flight and no writeback occurs.
- State machine: IDLE -> READ -> EXEC -> RETIRE -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr and go to READ.
- READ:
  - bus1 <= R[rs1], bus2 <= R[rs2] (registered).
  - All strobes 0.
- EXEC:
  - Exactly one strobe high, selected by opcode: 0 passthrough, 1 add, 2 sub, 3 shr, 4 shl, 5 band, 6 bor, 7 bxor, 8 bnegate.
  - At the EXEC->RETIRE edge, R[rd] <= bus3.
  - Opcode 9 (LDI): no strobe; R[rd] <= zero-extended instr[8:0].
  - Opcodes 10-15: no strobe, no write.
- RETIRE:
  - done = 1.
  - illegal = 1 if the opcode was 10-15.
  - Strobes 0. Go to IDLE.
- Latency and throughput: handshake edge at cycle 0; done is high in cycle 3. instr_ready is high only in IDLE, so one instruction per 4 cycles.
- bus1/bus2 hold their values from READ until the next READ.
- The sequencer never samples bus3 outside EXEC, because it is high-Z there.
- rd equal to rs1 or rs2 is legal: operands are already latched in READ, so the write takes effect for the next instruction.
- Arithmetic wraps modulo 2^DATA_W; that is logic_unit's responsibility. The sequencer stores bus3 verbatim.
- instr_valid deasserted in IDLE: hold in IDLE indefinitely, outputs stable.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN adds outputs zero_flag (1) and neg_flag (1), both reset to 0.
- Both flags update only at a writeback edge (EXEC->RETIRE edge, including LDI):
  - zero_flag = (value written == 0).
  - neg_flag = value written [DATA_W-1].
- Illegal opcodes leave the flags unchanged.
- Without the macro the ports do not exist and there is no flag logic.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants OP_PASS..OP_NOT, OP_LDI;
  - state encoding IDLE/READ/EXEC/RETIRE;
  - instruction field bit positions.
- One natural sub-module: alu_seq_regfile.
  - Two combinational read ports, one synchronous write port.
  - Asynchronous reset clears all entries.

Test Plan:
- Reset mid-EXEC of ADD R1 <- R2+R3 -> strobes drop immediately, R1 remains 0, instr_ready high one cycle after rst falls.
- LDI R2 <- 3; LDI R3 <- 2; ADD R1 <- R2,R3 with a logic_unit model -> add high exactly in cycle 2, bus1 = 3, bus2 = 2, R1 = 5, done in cycle 3.
- SUB R4 <- R2,R3 then PASS R5 <- R4 -> R4 = 1, R5 = 1; in every cycle at most one strobe is high.
- SUB R6 <- R3,R2 (2-3) -> R6 = 16'hFFFF. With ALU_SEQ_FLAGS_EN: neg_flag = 1, zero_flag = 0.
- Opcode 4'hC issued -> no strobe, no register change, illegal and done pulse together in cycle 3.
- instr_valid held high for back-to-back instructions -> accepted every 4th cycle, instr_ready low in READ/EXEC/RETIRE; ADD R2 <- R2,R2 with R2 = 3 gives 6.
